// File: rtl/conv_window_reader.sv
// conv_window_reader: sweeps every KxK stride-1 window of a row-major feature map and streams the taps.
// Optional zero padding of (K-1)/2 on every border is built when CONV_WIN_PAD_EN is defined.
module conv_window_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10,
  parameter int IMG_W = 8,
  parameter int K = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last_win,
  output logic              out_last
);
`ifdef CONV_WIN_PAD_EN
  localparam int P = (K - 1) / 2;
`else
  localparam int P = 0;
`endif
  localparam int NW = IMG_W - K + 1 + 2 * P;
  localparam int CW = $clog2(IMG_W + K) + 1;
  localparam logic [CW-1:0] K_LAST = CW'(K - 1);
  localparam logic [CW-1:0] N_LAST = CW'(NW - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] WIN_STEP = ADDR_W'(IMG_W - NW + 1);
  localparam logic [ADDR_W-1:0] ORIGIN = ADDR_W'(P * IMG_W + P);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] r, c, ky, kx;
  logic [ADDR_W-1:0] win, row, addr;
  logic [1:0] cnt, flw, flast;
  logic wp, rp, pv, pz, plw, plast;
  logic [DATA_W-1:0] fd [2];
  logic lkx, lky, lc, lr, fin, pop, issue, in_img;

  assign lkx = kx == K_LAST;
  assign lky = ky == K_LAST;
  assign lc = c == N_LAST;
  assign lr = r == N_LAST;
  assign fin = lkx & lky & lc & lr;
  assign out_valid = cnt != 2'd0;
  assign pop = out_valid & out_ready;
  // A slot freed by this cycle's pop is reusable at once, so a full-rate stream has no bubbles.
  assign issue = state == RUN && (3'(cnt) + 3'(pv) - 3'(pop)) < 3'd2;
`ifdef CONV_WIN_PAD_EN
  logic [CW-1:0] y, x;
  assign y = r + ky;
  assign x = c + kx;
  assign in_img = y >= CW'(P) && y < CW'(IMG_W + P) && x >= CW'(P) && x < CW'(IMG_W + P);
`else
  assign in_img = 1'b1;
`endif
  assign mem_rd_en = issue & in_img;
  assign mem_addr = addr;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
  assign out_data = out_valid ? fd[rp] : '0;
  assign out_last_win = out_valid & flw[rp];
  assign out_last = out_valid & flast[rp];

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? RUN : IDLE;
      RUN: state_nx = issue && fin ? DRAIN : RUN;
      DRAIN: state_nx = pop && out_last ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end

  // win tracks the window origin, row the current kernel row; addr is always row + kx.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r <= '0;
      c <= '0;
      ky <= '0;
      kx <= '0;
      win <= '0;
      row <= '0;
      addr <= '0;
    end else if (state == IDLE && start) begin
      r <= '0;
      c <= '0;
      ky <= '0;
      kx <= '0;
      win <= base_addr - ORIGIN;
      row <= base_addr - ORIGIN;
      addr <= base_addr - ORIGIN;
    end else if (issue) begin
      kx <= lkx ? '0 : kx + 1'b1;
      if (!lkx) addr <= addr + 1'b1;
      else if (!lky) begin
        ky <= ky + 1'b1;
        row <= row + ROW_STEP;
        addr <= row + ROW_STEP;
      end else if (!lc) begin
        ky <= '0;
        c <= c + 1'b1;
        win <= win + 1'b1;
        row <= win + 1'b1;
        addr <= win + 1'b1;
      end else begin
        ky <= '0;
        c <= '0;
        r <= lr ? '0 : r + 1'b1;
        win <= win + WIN_STEP;
        row <= win + WIN_STEP;
        addr <= win + WIN_STEP;
      end
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pv <= 1'b0;
      pz <= 1'b0;
      plw <= 1'b0;
      plast <= 1'b0;
      cnt <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      fd[0] <= '0;
      fd[1] <= '0;
      flw <= '0;
      flast <= '0;
    end else begin
      pv <= issue;
      pz <= !in_img;
      plw <= lkx & lky;
      plast <= fin;
      if (pv) begin
        fd[wp] <= pz ? '0 : mem_rd_data;
        flw[wp] <= plw;
        flast[wp] <= plast;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(pv) - 2'(pop);
    end
endmodule
